// File: rtl/vin_sonar_pkg.sv
// Shared types and widths for the sonar round-robin scheduler.
package vin_sonar_pkg;

    localparam int DIST_W = 32;
    localparam int CNT_W  = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT,
        S_MEAS,
        S_HOLD
    } state_t;

endpackage

// File: rtl/vin_sonar_sync.sv
// Parameterized-width two-flop synchronizer, synchronous active-high reset to 0.
module vin_sonar_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/vin_sonar_scheduler.sv
// Round-robin sonar sequencer: trigger, echo timing, holdoff, per-channel results.
// Optional SONAR_CHANNEL_MASK_EN adds an enable port that skips disabled channels.
//
// state  | meaning
// S_IDLE | pick channel (skip disabled ones when masking), one cycle
// S_TRIG | trigger[active_ch] high for TRIGGER_LEN cycles
// S_WAIT | wait up to ECHO_TIMEOUT cycles for echo_s to rise
// S_MEAS | count echo-high cycles, saturating at ECHO_MAX
// S_HOLD | quiet for HOLDOFF cycles, then advance to the next channel
module vin_sonar_scheduler
    import vin_sonar_pkg::*;
#(
    parameter int CHANNELS     = 4,
    parameter int TRIGGER_LEN  = 500,
    parameter int ECHO_TIMEOUT = 1500000,
    parameter int ECHO_MAX     = 2000000,
    parameter int HOLDOFF      = 500000,
    localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CHANNELS-1:0]          echo,
    output logic [CHANNELS-1:0]          trigger,
    output logic [CHANNELS*DIST_W-1:0]   distance,
    output logic [CHANNELS-1:0]          valid,
    output logic [CHANNELS-1:0]          timeout,
    output logic [CH_W-1:0]              active_ch
`ifdef SONAR_CHANNEL_MASK_EN
    ,
    input  logic [CHANNELS-1:0]          enable
`endif
);

    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIGGER_LEN - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(ECHO_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] MAX_LAST  = CNT_W'(ECHO_MAX - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF - 1);
    localparam logic [CNT_W-1:0] MAX_VAL   = CNT_W'(ECHO_MAX);
    localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(CHANNELS - 1);

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [CHANNELS-1:0] echo_s;
    logic              adv_ch;
    logic              wr_meas, wr_sat, wr_to;
    logic [CH_W-1:0]   next_ch;

    vin_sonar_sync #(.WIDTH(CHANNELS)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (echo),
        .q   (echo_s)
    );

    assign next_ch = (active_ch == LAST_CH) ? '0 : active_ch + 1'b1;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        adv_ch  = 1'b0;
        wr_meas = 1'b0;
        wr_sat  = 1'b0;
        wr_to   = 1'b0;
        case (state)
            S_IDLE: begin
`ifdef SONAR_CHANNEL_MASK_EN
                if (enable[active_ch]) begin
                    state_n = S_TRIG;
                    cnt_n   = '0;
                end else begin
                    adv_ch = 1'b1;
                end
`else
                state_n = S_TRIG;
                cnt_n   = '0;
`endif
            end
            S_TRIG: begin
                if (cnt >= TRIG_LAST) begin
                    state_n = S_WAIT;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_WAIT: begin
                // The cycle that sees the rise is already the first counted high cycle.
                if (echo_s[active_ch]) begin
                    state_n = S_MEAS;
                    cnt_n   = CNT_W'(1);
                end else if (cnt >= TO_LAST) begin
                    wr_to   = 1'b1;
                    state_n = S_HOLD;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_MEAS: begin
                if (!echo_s[active_ch]) begin
                    wr_meas = 1'b1;
                    state_n = S_HOLD;
                    cnt_n   = '0;
                end else if (cnt >= MAX_LAST) begin
                    wr_sat  = 1'b1;
                    state_n = S_HOLD;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt >= HOLD_LAST) begin
                    adv_ch  = 1'b1;
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            active_ch <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (adv_ch) begin
                active_ch <= next_ch;
            end
        end
    end

    // Whole distance word is written on one edge, so the host never sees a partial value.
    always_ff @(posedge clk) begin
        if (rst) begin
            distance <= '0;
            valid    <= '0;
            timeout  <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (CH_W'(i) == active_ch) begin
                    if (wr_meas) begin
                        distance[i*DIST_W +: DIST_W] <= cnt;
                        valid[i]   <= 1'b1;
                        timeout[i] <= 1'b0;
                    end
                    if (wr_sat) begin
                        distance[i*DIST_W +: DIST_W] <= MAX_VAL;
                        timeout[i] <= 1'b1;
                    end
                    if (wr_to) begin
                        timeout[i] <= 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        trigger = '0;
        if (state == S_TRIG) begin
            trigger[active_ch] = 1'b1;
        end
    end

endmodule

// File: tb/tb_vin_sonar_scheduler.sv
// Directed + randomized bench for vin_sonar_scheduler (CHANNELS=2, short timings).
// Builds with or without SONAR_CHANNEL_MASK_EN.
module tb_vin_sonar_scheduler;

    localparam int CH   = 2;
    localparam int TLEN = 4;
    localparam int ETO  = 20;
    localparam int EMAX = 50;
    localparam int HOLD = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [CH-1:0]   echo;
    logic [CH-1:0]   trigger;
    logic [CH*32-1:0] distance;
    logic [CH-1:0]   valid;
    logic [CH-1:0]   timeout;
    logic            active_ch;
    logic [CH-1:0]   en_model = 2'b11;
`ifdef SONAR_CHANNEL_MASK_EN
    logic [CH-1:0]   enable;
`endif

    vin_sonar_scheduler #(
        .CHANNELS(CH), .TRIGGER_LEN(TLEN), .ECHO_TIMEOUT(ETO),
        .ECHO_MAX(EMAX), .HOLDOFF(HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .echo      (echo),
        .trigger   (trigger),
        .distance  (distance),
        .valid     (valid),
        .timeout   (timeout),
        .active_ch (active_ch)
`ifdef SONAR_CHANNEL_MASK_EN
        ,
        .enable    (enable)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: per-channel results plus scheduling expectations.
    logic [31:0] m_dist [CH];
    logic [CH-1:0] m_valid;
    logic [CH-1:0] m_to;
    int exp_ch;
    int exp_gap;
    int low;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) m_dist[i] = '0;
        m_valid = '0;
        m_to    = '0;
        exp_ch  = 0;
        exp_gap = 1;
        low     = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_dist"},  distance, {m_dist[1], m_dist[0]});
        check({tag, "_valid"}, valid,   m_valid);
        check({tag, "_to"},    timeout, m_to);
    endtask

    // Waits for the next trigger pulse, checks spacing, channel, results and pulse width.
    task automatic wait_trigger();
        int n;
        while (trigger == '0 && low < 300) begin
            @(negedge clk);
            low++;
        end
        check("gap", low, exp_gap);
        check("trig_ch", trigger, 64'(1) << exp_ch);
        check("active_ch", active_ch, exp_ch);
        check_outputs("res");
        n = 0;
        while (trigger != '0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("trig_len", n, TLEN);
        low = 0;
    endtask

    // Echo rises d cycles into WAIT and stays high w cycles (w=0: no echo).
    task automatic drive_echo(input int d, input int w);
        int ch, k, nxt, extra;
        ch = exp_ch;
        for (int j = 0; j < d + w; j++) begin
            echo[ch] = (j >= d);
            @(negedge clk);
            low++;
        end
        echo = '0;
        k = d + 2;
        if (w == 0 || k >= ETO) begin
            m_to[ch] = 1'b1;
            exp_gap  = ETO + HOLD + 1;
        end else if (w >= EMAX) begin
            m_dist[ch] = EMAX;
            m_to[ch]   = 1'b1;
            exp_gap    = k + EMAX + HOLD + 1;
        end else begin
            m_dist[ch]  = w;
            m_valid[ch] = 1'b1;
            m_to[ch]    = 1'b0;
            exp_gap     = k + w + HOLD + 2;
        end
        nxt   = (ch + 1) % CH;
        extra = 0;
        while (!en_model[nxt]) begin
            nxt = (nxt + 1) % CH;
            extra++;
        end
        exp_gap += extra;
        exp_ch = nxt;
    endtask

    task automatic run_meas(input int d, input int w);
        wait_trigger();
        drive_echo(d, w);
    endtask

    task automatic run_random();
        int kind;
        kind = $urandom_range(3, 0);
        case (kind)
            0: run_meas($urandom_range(10, 0), $urandom_range(30, 1));
            1: run_meas($urandom_range(20, 0), 0);
            2: run_meas($urandom_range(20, 18), $urandom_range(5, 1));
            default: run_meas($urandom_range(5, 0), $urandom_range(58, 50));
        endcase
    endtask

    initial begin
        rst  = 1'b1;
        echo = '0;
`ifdef SONAR_CHANNEL_MASK_EN
        enable = en_model;
`endif
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_trig", trigger, 0);
        check("rst_ch", active_ch, 0);
        check_outputs("rst");
        @(negedge clk);
        rst = 1'b0;
        low = 0;

        run_meas(1, 10);
        run_meas(0, 0);
        run_meas(2, 58);
        run_meas(17, 5);
        run_meas(18, 3);
        run_meas(0, 49);
        run_meas(0, EMAX);
        for (int i = 0; i < 10; i++) run_random();
        if (exp_ch != 1) run_random();

        // Reset in the middle of a ch1 measurement.
        wait_trigger();
        for (int j = 0; j < 8; j++) begin
            echo[1] = 1'b1;
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_trig", trigger, 0);
        check("mrst_ch", active_ch, 0);
        check("mrst_dist", distance, 0);
        check("mrst_valid", valid, 0);
        check("mrst_to", timeout, 0);
        @(negedge clk);
        rst  = 1'b0;
        echo = '0;
        model_reset();
        run_meas(3, 12);
        run_meas(0, 0);

`ifdef SONAR_CHANNEL_MASK_EN
        wait_trigger();
        en_model = 2'b10;
        enable   = en_model;
        drive_echo(2, 7);
        for (int i = 0; i < 3; i++) run_random();
`endif
        wait_trigger();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
